// File: rtl/b6_pkg.sv
// Shared sizing for the B6 weight bank: channel/weight geometry and weight bit offsets.
package b6_pkg;
  localparam int NUM_OCH   = 5;
  localparam int NUM_W     = 64;
  localparam int W_BITS    = 7;
  localparam int GRP       = 4;
  localparam int NUM_GRP   = NUM_W / GRP;
  localparam int BANK_BITS = NUM_W * W_BITS;
  localparam int WORD_BITS = GRP * W_BITS;

  typedef logic [BANK_BITS-1:0] bank_t;
  typedef logic [WORD_BITS-1:0] word_t;

  function automatic int b6_w_slice(input int k);
    return k * W_BITS;
  endfunction
endpackage

// File: rtl/weight_bank_rd_mux.sv
// Combinational channel/group select feeding the registered read port.
// Word is MSB-first: w_4g lands in the top W_BITS, w_4g+3 in the bottom.
module weight_bank_rd_mux
  import b6_pkg::*;
(
  input  bank_t       banks_i [NUM_OCH],
  input  logic [2:0]  ch_i,
  input  logic [3:0]  grp_i,
  output word_t       word_o
);

  always_comb begin
    word_o = '0;
    for (int c = 0; c < NUM_OCH; c++) begin
      if (ch_i == 3'(c)) begin
        for (int j = 0; j < GRP; j++) begin
          word_o[(GRP-1-j)*W_BITS +: W_BITS] =
            banks_i[c][b6_w_slice(int'(grp_i)*GRP + j) +: W_BITS];
        end
      end
    end
  end

endmodule

// File: rtl/weight_bank_b6.sv
// Captures loader weight snapshots into per-channel banks on each thermometer flag step,
// and serves 4-weight rows through a fixed 1-cycle registered read port.
module weight_bank_b6
  import b6_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BANK_BITS-1:0]  w_bus,
  input  logic [NUM_OCH-1:0]    new_weight_val,
  input  logic                  trans_done,
  input  logic                  clr,
  input  logic                  rd_req,
  input  logic [2:0]            rd_ch,
  input  logic [3:0]            rd_grp,
  output logic [WORD_BITS-1:0]  rd_data,
  output logic                  rd_vld,
  output logic                  rd_err,
  output logic [NUM_OCH-1:0]    bank_valid,
  output logic                  all_loaded
);

  localparam logic [NUM_OCH-1:0] ONE = {{(NUM_OCH-1){1'b0}}, 1'b1};

  bank_t               banks_q [NUM_OCH];
  logic [NUM_OCH-1:0]  nwv_q, bank_valid_q, bank_valid_d;
  logic                done_seen_q, done_seen_d;
  logic                all_loaded_q, all_loaded_d;
  logic                seq_err_q, seq_err_d;
  word_t               rd_data_q, rd_data_d, mux_word;
  logic                rd_vld_q, rd_vld_d, rd_err_q, rd_err_d;

  logic [NUM_OCH-1:0]  new_bits, below_mask;
  logic [7:0]          valid_pad;
  logic                one_new, cap_ok, cap_en, rd_hit;

  weight_bank_rd_mux u_rd_mux (
    .banks_i (banks_q),
    .ch_i    (rd_ch),
    .grp_i   (rd_grp),
    .word_o  (mux_word)
  );

  always_comb begin
    new_bits   = new_weight_val & ~nwv_q;
    // For a one-hot rising bit, subtracting one yields the mask of all channels below it.
    below_mask = new_bits - ONE;
    one_new    = (new_bits != '0) && ((new_bits & below_mask) == '0);
    cap_ok     = one_new && ((new_weight_val & below_mask) == below_mask);
    cap_en     = cap_ok && !clr;

    bank_valid_d = cap_en ? (bank_valid_q | new_bits) : bank_valid_q;
    seq_err_d    = seq_err_q | ((new_bits != '0) && !cap_ok);
    done_seen_d  = done_seen_q | trans_done;
    if (clr) begin
      bank_valid_d = '0;
      seq_err_d    = 1'b0;
      done_seen_d  = 1'b0;
    end
    all_loaded_d = (&bank_valid_d) & done_seen_d;

    // Out-of-range channels index the zero padding and so read as unloaded.
    valid_pad = 8'(bank_valid_q);
    rd_hit    = rd_req && valid_pad[rd_ch];
    rd_vld_d  = rd_hit;
    rd_err_d  = rd_req && !rd_hit;
    rd_data_d = rd_hit ? mux_word : (rd_req ? '0 : rd_data_q);
  end

  // Bank contents are deliberately outside reset; bank_valid gates their use.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_OCH; c++) begin
      if (cap_en && new_bits[c]) banks_q[c] <= w_bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nwv_q        <= '0;
      bank_valid_q <= '0;
      done_seen_q  <= 1'b0;
      all_loaded_q <= 1'b0;
      seq_err_q    <= 1'b0;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      nwv_q        <= new_weight_val;
      bank_valid_q <= bank_valid_d;
      done_seen_q  <= done_seen_d;
      all_loaded_q <= all_loaded_d;
      seq_err_q    <= seq_err_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_vld     = rd_vld_q;
  assign rd_err     = rd_err_q;
  assign bank_valid = bank_valid_q;
  assign all_loaded = all_loaded_q;

endmodule

// File: tb/tb_weight_bank_b6.sv
// Randomized scoreboard bench for weight_bank_b6 against a behavioural loader/bank model.
module tb_weight_bank_b6;
  import b6_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [BANK_BITS-1:0]  w_bus;
  logic [NUM_OCH-1:0]    new_weight_val;
  logic                  trans_done, clr, rd_req;
  logic [2:0]            rd_ch;
  logic [3:0]            rd_grp;
  logic [WORD_BITS-1:0]  rd_data;
  logic                  rd_vld, rd_err, all_loaded;
  logic [NUM_OCH-1:0]    bank_valid;

  always #5 clk = ~clk;

  weight_bank_b6 dut (
    .clk(clk), .rst_n(rst_n), .w_bus(w_bus), .new_weight_val(new_weight_val),
    .trans_done(trans_done), .clr(clr), .rd_req(rd_req), .rd_ch(rd_ch), .rd_grp(rd_grp),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_err(rd_err),
    .bank_valid(bank_valid), .all_loaded(all_loaded)
  );

  typedef struct packed {
    logic                 vld;
    logic                 err;
    logic [WORD_BITS-1:0] dat;
  } rsp_t;

  rsp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] m_bank [NUM_OCH][NUM_W];
  logic [4:0] m_valid, m_prev;
  logic       m_done, m_seq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BANK_BITS-1:0] rand_bus();
    logic [BANK_BITS-1:0] b;
    for (int i = 0; i < BANK_BITS; i++) b[i] = 1'($urandom);
    return b;
  endfunction

  function automatic logic [BANK_BITS-1:0] pat_bus(input int c, input int off);
    logic [BANK_BITS-1:0] b;
    for (int k = 0; k < NUM_W; k++) b[k*7 +: 7] = 7'((c*64 + k + off) % 128);
    return b;
  endfunction

  function automatic logic [4:0] therm(input int n);
    return 5'((1 << n) - 1);
  endfunction

  // One clock of stimulus: queue the read response from the pre-edge model, then advance the model.
  task automatic step(input logic [4:0] flag, input logic [BANK_BITS-1:0] wb, input logic td,
                      input logic cl, input logic rq, input logic [2:0] ch, input logic [3:0] g);
    rsp_t r;
    logic [4:0] rise;
    int k;
    bit ok;
    new_weight_val = flag; w_bus = wb; trans_done = td; clr = cl;
    rd_req = rq; rd_ch = ch; rd_grp = g;
    if (rq) begin
      r = '0;
      if (int'(ch) >= NUM_OCH) r.err = 1'b1;
      else if (!m_valid[ch]) r.err = 1'b1;
      else begin
        r.vld = 1'b1;
        for (int j = 0; j < GRP; j++) r.dat[(GRP-1-j)*7 +: 7] = m_bank[ch][int'(g)*GRP + j];
      end
      exp_q.push_back(r);
    end
    rise = flag & ~m_prev;
    if (cl) begin
      m_valid = '0; m_done = 1'b0; m_seq = 1'b0;
    end else begin
      if ($countones(rise) == 1) begin
        k = 0;
        for (int i = 0; i < NUM_OCH; i++) if (rise[i]) k = i;
        ok = 1'b1;
        for (int i = 0; i < k; i++) if (!flag[i]) ok = 1'b0;
        if (ok) begin
          for (int i = 0; i < NUM_W; i++) m_bank[k][i] = wb[i*7 +: 7];
          m_valid[k] = 1'b1;
        end else m_seq = 1'b1;
      end else if (rise != '0) m_seq = 1'b1;
      if (td) m_done = 1'b1;
    end
    m_prev = flag;
    @(posedge clk); #1;
    chk("bank_valid", bank_valid, m_valid);
    chk("all_loaded", all_loaded, (&m_valid) & m_done);
    chk("seq_err_q", dut.seq_err_q, m_seq);
  endtask

  task automatic step_rr(input logic [4:0] flag, input logic [BANK_BITS-1:0] wb,
                         input logic td, input logic cl);
    step(flag, wb, td, cl, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         4'($urandom_range(0, 15)));
  endtask

  task automatic load_all(input int off);
    step_rr(5'h00, rand_bus(), 1'b0, 1'b0);
    for (int c = 0; c < NUM_OCH; c++) begin
      repeat (2) step_rr(therm(c), rand_bus(), 1'b0, 1'b0);
      // Channel 1 is read on the very cycle its flag bit rises: must report unloaded.
      if (c == 1) step(therm(c+1), pat_bus(c, off), 1'b0, 1'b0, 1'b1, 3'd1, 4'($urandom_range(0, 15)));
      else        step_rr(therm(c+1), pat_bus(c, off), 1'b0, 1'b0);
    end
    step_rr(5'h1f, rand_bus(), 1'b1, 1'b0);
    step_rr(5'h1f, rand_bus(), 1'b0, 1'b0);
  endtask

  task automatic sweep();
    for (int c = 0; c < NUM_OCH; c++)
      for (int g = 0; g < NUM_GRP; g++)
        step(5'h1f, rand_bus(), 1'b0, 1'b0, 1'b1, 3'(c), 4'(g));
  endtask

  task automatic monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rd_vld || rd_err)) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected: vld=%0b err=%0b data=%0h with nothing outstanding", rd_vld, rd_err, rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_vld", rd_vld, e.vld);
          chk("rd_err", rd_err, e.err);
          chk("rd_data", rd_data, e.dat);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; w_bus = '0; new_weight_val = '0; trans_done = 1'b0; clr = 1'b0;
    rd_req = 1'b0; rd_ch = '0; rd_grp = '0;
    m_valid = '0; m_prev = '0; m_done = 1'b0; m_seq = 1'b0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bank_valid", bank_valid, 0);
    chk("rst_all_loaded", all_loaded, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    load_all(0);
    step(5'h1f, rand_bus(), 1'b0, 1'b0, 1'b1, 3'd2, 4'd15);
    sweep();

    // Overwrite channel 1; a same-cycle read returns the old contents, the next read the new.
    step(5'h1d, rand_bus(), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(5'h1f, pat_bus(1, 77), 1'b0, 1'b0, 1'b1, 3'd1, 4'd15);
    step(5'h1f, rand_bus(), 1'b0, 1'b0, 1'b1, 3'd1, 4'd15);

    // clr with a read in the same cycle, then the cleared bank reads as unloaded.
    step(5'h1f, rand_bus(), 1'b0, 1'b1, 1'b1, 3'd0, 4'd3);
    step(5'h1f, rand_bus(), 1'b0, 1'b0, 1'b1, 3'd0, 4'd3);

    // Partial load of three channels.
    step(5'h00, rand_bus(), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    for (int c = 0; c < 3; c++) step(therm(c+1), pat_bus(c, 5), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(5'h07, rand_bus(), 1'b0, 1'b0, 1'b1, 3'd3, 4'd2);
    step(5'h07, rand_bus(), 1'b0, 1'b0, 1'b1, 3'd5, 4'd2);
    step(5'h07, rand_bus(), 1'b0, 1'b0, 1'b1, 3'd2, 4'd0);

    // Flag skipping a channel must not capture.
    step(5'h00, rand_bus(), 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    step(5'h01, pat_bus(0, 9), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(5'h07, pat_bus(1, 9), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step_rr(5'h07, rand_bus(), 1'b0, 1'b0);

    // Async reset in the middle of a load.
    step(5'h00, rand_bus(), 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    step(5'h01, pat_bus(0, 33), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(5'h03, pat_bus(1, 33), 1'b1, 1'b0, 1'b1, 3'd0, 4'd1);
    rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_bank_valid", bank_valid, 0);
    chk("arst_all_loaded", all_loaded, 0);
    chk("arst_rd_vld", rd_vld, 0);
    chk("arst_rd_err", rd_err, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_seq_err", dut.seq_err_q, 0);
    exp_q.delete();
    m_valid = '0; m_prev = '0; m_done = 1'b0; m_seq = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    load_all(int'($urandom_range(0, 127)));
    sweep();
    for (int i = 0; i < 300; i++) step_rr(5'h1f, rand_bus(), 1'($urandom_range(0, 1)), 1'b0);

    step(5'h1f, rand_bus(), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(5'h1f, rand_bus(), 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    chk("sb_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
